// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter high byte (PCH) block.
// Covers the carry/borrow handshake state and the PCH load-source select.
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    RELEASE = 2'd2
  } pch_state_t;

  typedef enum logic [2:0] {
    SelHold = 3'd0,
    SelDb   = 3'd1,
    SelVec  = 3'd2,
    SelAdb  = 3'd3,
    SelInc  = 3'd4,
    SelDec  = 3'd5
  } pch_sel_t;

  localparam logic [7:0] VEC_PAGE   = 8'hFF;
  localparam logic [7:0] VEC_RES_LO = 8'hFC;
  localparam logic [7:0] VEC_IRQ_LO = 8'hFE;
  localparam logic [7:0] VEC_NMI_LO = 8'hFA;

  // Load priority: decode > any vector fetch > address bus > inc > dec.
  function automatic pch_sel_t pch_select(input logic decode, input logic vec,
                                          input logic adb, input logic inc,
                                          input logic dec);
    pch_sel_t sel;
    sel = SelHold;
    if (decode) begin
      sel = SelDb;
    end else if (vec) begin
      sel = SelVec;
    end else if (adb) begin
      sel = SelAdb;
    end else if (inc) begin
      sel = SelInc;
    end else if (dec) begin
      sel = SelDec;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pch_carry_fsm.sv
// Carry (and optional borrow, PCH_BORROW_EN) handshake FSM for PCH.
// Grants exactly one increment/decrement per request assertion and pulses the acknowledges.
module pch_carry_fsm (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic carry_i,
`ifdef PCH_BORROW_EN
  input  logic borrow_i,
  input  logic pch_is_00_i,
  output logic dec_en_o,
  output logic borrow_done_o,
`endif
  input  logic load_active_i,
  input  logic pch_is_ff_i,
  output logic inc_en_o,
  output logic carry_done_o,
  output logic pc_wrap_o
);
  import pc_pkg::*;

  pch_state_t state_q, state_d;
  logic       carry_done_q, carry_done_d;
  logic       pc_wrap_q, pc_wrap_d;
  logic       req_any;
  logic       inc_en;
`ifdef PCH_BORROW_EN
  logic       borrow_done_q, borrow_done_d;
  logic       dec_en;

  assign req_any = carry_i | borrow_i;
`else
  assign req_any = carry_i;
`endif

  always_comb begin
    state_d      = state_q;
    carry_done_d = 1'b0;
    pc_wrap_d    = 1'b0;
    inc_en       = 1'b0;
`ifdef PCH_BORROW_EN
    borrow_done_d = 1'b0;
    dec_en        = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_any) begin
          state_d      = ACK;
          carry_done_d = carry_i;
`ifdef PCH_BORROW_EN
          borrow_done_d = borrow_i;
          // Simultaneous carry and borrow cancel: acknowledge both, leave PCH alone.
          if (!load_active_i) begin
            inc_en    = carry_i & ~borrow_i;
            dec_en    = borrow_i & ~carry_i;
            pc_wrap_d = (inc_en & pch_is_ff_i) | (dec_en & pch_is_00_i);
          end
`else
          // A concurrent load wins; the carry is still acknowledged so PCL can clear its flag.
          if (!load_active_i) begin
            inc_en    = carry_i;
            pc_wrap_d = carry_i & pch_is_ff_i;
          end
`endif
        end
      end
      ACK: begin
        state_d = req_any ? RELEASE : IDLE;
      end
      RELEASE: begin
        if (!req_any) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      carry_done_q <= 1'b0;
      pc_wrap_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      carry_done_q <= carry_done_d;
      pc_wrap_q    <= pc_wrap_d;
    end
  end

`ifdef PCH_BORROW_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      borrow_done_q <= 1'b0;
    end else begin
      borrow_done_q <= borrow_done_d;
    end
  end

  assign dec_en_o      = dec_en;
  assign borrow_done_o = borrow_done_q;
`endif

  assign inc_en_o     = inc_en;
  assign carry_done_o = carry_done_q;
  assign pc_wrap_o    = pc_wrap_q;

endmodule

// File: rtl/pch.sv
// Program counter high byte: register, prioritized load mux and the PCL carry handshake.
// Optional borrow path for backward page-crossing branches is enabled by PCH_BORROW_EN.
module pch #(
  parameter logic [7:0] VEC_PAGE  = pc_pkg::VEC_PAGE,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       fclk,
  input  logic       resb,
  input  logic       instruction_decode_in,
  input  logic       push_resb,
  input  logic       push_irqb,
  input  logic       push_nmib,
  input  logic       adb_to_pc,
  input  logic [7:0] db_in,
  output logic [7:0] db_out,
  input  logic [7:0] address_high_in,
  output logic [7:0] address_high_out,
  input  logic       carry_to_pch,
  output logic       carry_done,
`ifdef PCH_BORROW_EN
  input  logic       borrow_to_pch,
  output logic       borrow_done,
`endif
  output logic       pc_wrap
);
  import pc_pkg::*;

  logic [7:0] pch_q, pch_d;
  logic       vec_load;
  logic       load_active;
  logic       inc_en;
  logic       dec_en;
  pch_sel_t   sel;

  assign vec_load    = push_resb | push_irqb | push_nmib;
  assign load_active = instruction_decode_in | vec_load | adb_to_pc;

  pch_carry_fsm u_carry_fsm (
    .clk_i         (fclk),
    .rst_ni        (resb),
    .carry_i       (carry_to_pch),
`ifdef PCH_BORROW_EN
    .borrow_i      (borrow_to_pch),
    .pch_is_00_i   (pch_q == 8'h00),
    .dec_en_o      (dec_en),
    .borrow_done_o (borrow_done),
`endif
    .load_active_i (load_active),
    .pch_is_ff_i   (pch_q == 8'hFF),
    .inc_en_o      (inc_en),
    .carry_done_o  (carry_done),
    .pc_wrap_o     (pc_wrap)
  );

`ifndef PCH_BORROW_EN
  assign dec_en = 1'b0;
`endif

  assign sel = pch_select(instruction_decode_in, vec_load, adb_to_pc, inc_en, dec_en);

  always_comb begin
    pch_d = pch_q;
    unique case (sel)
      SelDb:   pch_d = db_in;
      SelVec:  pch_d = VEC_PAGE;
      SelAdb:  pch_d = address_high_in;
      SelInc:  pch_d = pch_q + 8'd1;
      SelDec:  pch_d = pch_q - 8'd1;
      default: pch_d = pch_q;
    endcase
  end

  always_ff @(posedge fclk or negedge resb) begin
    if (!resb) begin
      pch_q <= RESET_VAL;
    end else begin
      pch_q <= pch_d;
    end
  end

  assign db_out           = pch_q;
  assign address_high_out = pch_q;

endmodule

// File: tb/tb_pch.sv
// Self-checking bench for pch: vector table through a scoreboard queue, plus
// hand-written reset-mid-handshake and (with PCH_BORROW_EN) borrow sequences.
module tb_pch;

  logic       fclk = 1'b0;
  logic       resb;
  logic       instruction_decode_in, push_resb, push_irqb, push_nmib, adb_to_pc;
  logic [7:0] db_in, address_high_in;
  logic [7:0] db_out, address_high_out;
  logic       carry_to_pch, carry_done, pc_wrap;
`ifdef PCH_BORROW_EN
  logic       borrow_to_pch, borrow_done;
`endif

  int checks = 0;
  int errors = 0;

  pch dut (
    .fclk                  (fclk),
    .resb                  (resb),
    .instruction_decode_in (instruction_decode_in),
    .push_resb             (push_resb),
    .push_irqb             (push_irqb),
    .push_nmib             (push_nmib),
    .adb_to_pc             (adb_to_pc),
    .db_in                 (db_in),
    .db_out                (db_out),
    .address_high_in       (address_high_in),
    .address_high_out      (address_high_out),
    .carry_to_pch          (carry_to_pch),
    .carry_done            (carry_done),
`ifdef PCH_BORROW_EN
    .borrow_to_pch         (borrow_to_pch),
    .borrow_done           (borrow_done),
`endif
    .pc_wrap               (pc_wrap)
  );

  always #5 fclk = ~fclk;

  typedef struct {
    logic       id, pr, pi, pn, adb, carry;
    logic [7:0] db, ah;
    logic [7:0] e_pch;
    logic       e_done, e_wrap;
  } vec_t;

  typedef struct packed {
    logic [7:0] pch;
    logic       done;
    logic       wrap;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[19];

  function automatic vec_t mk(input logic id, pr, pi, pn, adb, carry,
                              input logic [7:0] db, ah, e_pch,
                              input logic e_done, e_wrap);
    vec_t v;
    v.id = id; v.pr = pr; v.pi = pi; v.pn = pn; v.adb = adb; v.carry = carry;
    v.db = db; v.ah = ah; v.e_pch = e_pch; v.e_done = e_done; v.e_wrap = e_wrap;
    return v;
  endfunction

  task automatic chk(input string what, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h, expected %h", what, idx, act, exp);
    end
  endtask

  task automatic clear_inputs();
    instruction_decode_in = 1'b0; push_resb = 1'b0; push_irqb = 1'b0;
    push_nmib = 1'b0; adb_to_pc = 1'b0; carry_to_pch = 1'b0;
    db_in = 8'h00; address_high_in = 8'h00;
`ifdef PCH_BORROW_EN
    borrow_to_pch = 1'b0;
`endif
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    @(negedge fclk);
    instruction_decode_in = v.id; push_resb = v.pr; push_irqb = v.pi;
    push_nmib = v.pn; adb_to_pc = v.adb; carry_to_pch = v.carry;
    db_in = v.db; address_high_in = v.ah;
    sb.push_back('{pch: v.e_pch, done: v.e_done, wrap: v.e_wrap});
    @(posedge fclk);
    #1;
    e = sb.pop_front();
    chk("address_high_out", idx, address_high_out, e.pch);
    chk("db_out", idx, db_out, e.pch);
    chk("carry_done", idx, {7'd0, carry_done}, {7'd0, e.done});
    chk("pc_wrap", idx, {7'd0, pc_wrap}, {7'd0, e.wrap});
  endtask

  initial begin
    // id pr pi pn adb carry db ah -> pch done wrap
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 8'h12, 8'h00, 8'h12, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h13, 1, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h13, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h13, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h13, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 1, 0, 8'h00, 8'hFF, 8'hFF, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 1, 1);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    tbl[9]  = mk(0, 0, 0, 1, 1, 0, 8'h00, 8'h34, 8'hFF, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 1, 0, 8'h00, 8'h34, 8'h34, 0, 0);
    tbl[11] = mk(0, 1, 0, 0, 0, 1, 8'h00, 8'h00, 8'hFF, 1, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'hFF, 0, 0);
    tbl[13] = mk(1, 0, 1, 0, 0, 0, 8'hAB, 8'h00, 8'hAB, 0, 0);
    tbl[14] = mk(0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'hFF, 0, 0);
    tbl[15] = mk(0, 0, 0, 0, 1, 0, 8'h00, 8'h10, 8'h10, 0, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h11, 1, 0);
    tbl[17] = mk(1, 0, 0, 0, 0, 1, 8'h55, 8'h00, 8'h55, 0, 0);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h55, 0, 0);

    clear_inputs();
    resb = 1'b0;
    #12;
    chk("reset address_high_out", -1, address_high_out, 8'h00);
    chk("reset db_out", -1, db_out, 8'h00);
    chk("reset carry_done", -1, {7'd0, carry_done}, 8'h00);
    chk("reset pc_wrap", -1, {7'd0, pc_wrap}, 8'h00);
    @(negedge fclk);
    resb = 1'b1;

    for (int i = 0; i < 19; i++) begin
      run_vec(tbl[i], i);
    end

    // Reset while carry_done is high must clear it without waiting for a clock.
    @(negedge fclk);
    clear_inputs();
    carry_to_pch = 1'b1;
    @(posedge fclk);
    #1;
    chk("pre-reset carry_done", 100, {7'd0, carry_done}, 8'h01);
    chk("pre-reset pch", 100, address_high_out, 8'h56);
    #2;
    resb = 1'b0;
    #1;
    chk("async reset carry_done", 101, {7'd0, carry_done}, 8'h00);
    chk("async reset pch", 101, address_high_out, 8'h00);
    @(negedge fclk);
    carry_to_pch = 1'b0;
    resb = 1'b1;
    run_vec(mk(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h01, 1, 0), 102);
    run_vec(mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h01, 0, 0), 103);

`ifdef PCH_BORROW_EN
    run_vec(mk(0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0), 200);
    @(negedge fclk);
    clear_inputs();
    borrow_to_pch = 1'b1;
    @(posedge fclk);
    #1;
    chk("borrow pch", 201, address_high_out, 8'hFF);
    chk("borrow_done", 201, {7'd0, borrow_done}, 8'h01);
    chk("borrow pc_wrap", 201, {7'd0, pc_wrap}, 8'h01);
    chk("borrow carry_done", 201, {7'd0, carry_done}, 8'h00);
    @(negedge fclk);
    borrow_to_pch = 1'b0;
    @(posedge fclk);
    #1;
    chk("borrow_done drop", 202, {7'd0, borrow_done}, 8'h00);
    run_vec(mk(0, 0, 0, 0, 1, 0, 8'h00, 8'h40, 8'h40, 0, 0), 203);
    @(negedge fclk);
    clear_inputs();
    borrow_to_pch = 1'b1;
    carry_to_pch  = 1'b1;
    @(posedge fclk);
    #1;
    chk("both pch", 204, address_high_out, 8'h40);
    chk("both borrow_done", 204, {7'd0, borrow_done}, 8'h01);
    chk("both carry_done", 204, {7'd0, carry_done}, 8'h01);
    chk("both pc_wrap", 204, {7'd0, pc_wrap}, 8'h00);
    @(negedge fclk);
    carry_to_pch = 1'b0;
    @(posedge fclk);
    #1;
    chk("release hold pch", 205, address_high_out, 8'h40);
    @(negedge fclk);
    borrow_to_pch = 1'b0;
    carry_to_pch  = 1'b1;
    @(posedge fclk);
    #1;
    // Still in RELEASE here: carry stays high, so no new increment yet.
    chk("release no inc", 206, address_high_out, 8'h40);
    chk("release no done", 206, {7'd0, carry_done}, 8'h00);
    @(negedge fclk);
    carry_to_pch = 1'b0;
    @(posedge fclk);
    #1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pch.md
Name: pch

Overview:
- Program counter high byte; the receiving end of the PCL carry handshake.
- Holds PC[15:8] and drives it on the address-high bus and the data bus for stack pushes.
- Loads from the data bus, the interrupt/reset vector page, or the address-high bus.
- Consumes carry_to_pch from PCL, increments exactly once per carry event, and returns carry_done so PCL clears its carry flag.

Parameters:
- VEC_PAGE, 8'hFF, high byte loaded on any reset/IRQ/NMI vector fetch.
- RESET_VAL, 8'h00, value of the PCH register after resb.

Ports:
- fclk  in  1  core clock; all state updates on rising edge
- resb  in  1  asynchronous, active-low reset
- instruction_decode_in  in  1  load PCH from db_in
- push_resb  in  1  load VEC_PAGE (reset vector)
- push_irqb  in  1  load VEC_PAGE (IRQ/BRK vector)
- push_nmib  in  1  load VEC_PAGE (NMI vector)
- adb_to_pc  in  1  load PCH from address_high_in
- db_in  in  8  data bus input
- db_out  out  8  PCH onto data bus (stack push)
- address_high_in  in  8  address bus high byte
- address_high_out  out  8  current PCH
- carry_to_pch  in  1  level carry request from PCL; held until carry_done
- carry_done  out  1  one-cycle acknowledge to PCL
- pc_wrap  out  1  one-cycle pulse when PCH wraps FF->00 on a carry

Behaviour:
- Reset: asynchronous on resb low.
  - PCH = RESET_VAL, FSM = IDLE.
  - carry_done = 0, pc_wrap = 0.
  - db_out = address_high_out = RESET_VAL.
- Load priority, highest first:
  - instruction_decode_in
  - push_resb
  - push_irqb
  - push_nmib
  - adb_to_pc
  - carry/borrow increment
- Every load takes effect at the next fclk edge.
- db_out and address_high_out are combinational copies of the PCH register.
- Carry FSM states are IDLE, ACK and RELEASE:
  - IDLE, carry_to_pch=1, no load active: PCH <= PCH+1 (mod 256) at the same edge; go to ACK. If PCH was FF, pc_wrap is high during the ACK cycle.
  - IDLE, carry_to_pch=1, load active: the load wins and the increment is discarded; still go to ACK so that PCL clears its flag.
  - ACK: carry_done=1 for exactly this one cycle. Next state is RELEASE if carry_to_pch=1, else IDLE.
  - RELEASE: carry_done=0 and no increment. Wait for carry_to_pch=0, then go to IDLE. This guarantees one increment per assertion even if PCL holds carry for several cycles.
- Latency: carry sampled at edge N; PCH updated at edge N; carry_done high from N to N+1.
- carry_done and pc_wrap are registered, glitch-free and never high for two consecutive cycles.
- A load during ACK or RELEASE is honoured normally; the FSM is unaffected.
- Reset mid-handshake: FSM returns to IDLE and carry_done is deasserted immediately (asynchronous).

Optional Feature:
- Macro: PCH_BORROW_EN.
- Defined:
  - Adds ports borrow_to_pch (in, 1) and borrow_done (out, 1).
  - Used for backward relative branches that cross a page.
  - The same FSM handles borrow with a direction bit: PCH <= PCH-1, and borrow_done pulses in ACK.
  - 00->FF on a borrow also pulses pc_wrap.
  - carry and borrow asserted together in IDLE: PCH is unchanged, carry_done and borrow_done both pulse, and RELEASE waits for both to be low.
- Undefined: no borrow ports and no borrow logic; only the carry path exists.

Decomposition:
- Package pc_pkg:
  - pch_state_t enum {IDLE, ACK, RELEASE}.
  - Constants VEC_PAGE=8'hFF, VEC_RES_LO=8'hFC, VEC_IRQ_LO=8'hFE, VEC_NMI_LO=8'hFA.
- Sub-module pch_carry_fsm: owns the handshake state and produces the inc/dec enables, carry_done, borrow_done and pc_wrap qualifiers.
- The pch top holds the register and the load mux.

Test Plan:
- Release resb with no loads -> PCH=00, carry_done=0, outputs 00.
- instruction_decode_in=1 with db_in=8'h12 -> address_high_out=12 after one edge; db_out=12.
- PCH=12, carry_to_pch held high 3 cycles -> PCH=13 (one increment only), carry_done high for exactly 1 cycle, FSM passes through RELEASE.
- PCH=FF, carry pulse -> PCH=00, pc_wrap high 1 cycle alongside carry_done.
- push_nmib and adb_to_pc together with address_high_in=34 -> PCH=FF; then adb_to_pc alone -> 34. Carry with push_resb at the same edge -> PCH=FF, no increment, carry_done still pulses.
- PCH_BORROW_EN defined, PCH=00, borrow pulse -> PCH=FF, borrow_done and pc_wrap pulse. Carry and borrow together at PCH=40 -> PCH stays 40, both dones pulse.
